peasant_mult_arbiter: RTL
=========================

# peasant_mult_arbiter

Round-robin arbiter and sequencer that shares one shift-add (peasant) multiplier among NREQ requesters. It accepts operand pairs over per-requester valid/ready handshakes and drives the multiplier's load and operand lines. It then waits for the multiplier's done flag and returns the 2N-bit product, tagged with the requester index, over a single valid/ready response port. It sits between client blocks and one `peasant_multi_nxn`-class multiplier instance.

## Interface
- `N`, default 16: operand width; the product is 2N bits.
- `NREQ`, default 4: number of requesters, 2..8.
- `IDW`, default $clog2(NREQ): requester-index width.

Ports:
- `clk_i` in 1: the single clock; everything is registered on the rising edge.
- `rst_i` in 1: synchronous, active-low reset.
- `req_valid_i` in NREQ: per-requester operand valid.
- `req_a_i` in NREQ*N: packed multiplicands; requester k occupies bits [k*N +: N].
- `req_b_i` in NREQ*N: packed multipliers, same packing.
- `req_ready_o` out NREQ: one-hot grant; at most one bit is high per cycle.
- `mul_load_o` out 1: multiplier load strobe, high while the operands are loaded.
- `mul_a_o`, `mul_b_o` out N each: operands to the multiplier, held stable from LOAD through RUN.
- `mul_done_i` in 1: multiplier finished flag, level.
- `mul_y_i` in 2N: multiplier product.
- `rsp_valid_o` out 1: response valid.
- `rsp_ready_i` in 1: response accept.
- `rsp_id_o` out IDW: index of the requester that owns the product.
- `rsp_y_o` out 2N: product.
- `busy_o` out 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, LOAD, RUN, RESP.
- **IDLE**
  - If any `req_valid_i` bit is high, grant the first valid requester at or after `ptr+1` (mod NREQ).
  - Assert that requester's `req_ready_o` combinationally in this cycle.
  - Capture its operands and index, set `ptr` to the granted index, and go to LOAD.
  - With no valid requester, stay in IDLE.
- **LOAD**: `mul_load_o`=1 for exactly one cycle, with `mul_a_o`/`mul_b_o` driven from the captured operands. Go to RUN.
- **RUN**
  - `mul_load_o`=0.
  - `mul_done_i` is ignored in the first RUN cycle, because the flag may be stale from the previous job.
  - From the second RUN cycle on, `mul_done_i`=1 captures `mul_y_i` into `rsp_y_o` and moves to RESP.
- **RESP**
  - `rsp_valid_o`=1; `rsp_id_o` and `rsp_y_o` are held stable.
  - On `rsp_valid_o & rsp_ready_i`, go to IDLE.
  - No new grant is issued while in RESP.
- Round-robin pointer `ptr` resets to NREQ-1, so requester 0 wins first after reset.
- A requester that deasserts `req_valid_i` before being granted loses nothing; nothing was captured for it.
- Products are not modified; the width of `rsp_y_o` is exactly 2N.
- Reset mid-operation: the FSM returns to IDLE, `ptr` returns to NREQ-1, and any in-flight product is discarded.

## Timing
- Reset values:
  - `req_ready_o`=0, `mul_load_o`=0, `mul_a_o`=`mul_b_o`=0.
  - `rsp_valid_o`=0, `rsp_id_o`=0, `rsp_y_o`=0, `busy_o`=0.
- Grant handshake completes in cycle T. `mul_load_o` is high in cycle T+1. RUN starts at T+2.
- If `mul_done_i` is first seen high in cycle D ≥ T+3, then `rsp_valid_o` rises in cycle D+1.
- Response accepted in cycle R: IDLE at R+1, and the next grant is possible in R+1.
- Worst-case multiplier latency is not bounded by this block; RUN waits indefinitely.
- `req_ready_o` is high only in IDLE and only for a requester whose `req_valid_i` is high.

## Configuration
- `PEASANT_ARB_ZERO_BYPASS_EN` defined:
  - If the captured a==0 or b==0, IDLE goes directly to RESP with `rsp_y_o`=0.
  - `mul_load_o` is never asserted for that job.
  - Grant in T gives `rsp_valid_o` in T+1.
- Not defined: every job goes through LOAD/RUN regardless of operand values.

## Test plan
- Single request: after reset, requester 2 presents a=13, b=11. Required: `req_ready_o`=4'b0100 in T, `mul_load_o` in T+1. A multiplier model asserts done at T+6, so response in T+7 with `rsp_y_o`=143 and `rsp_id_o`=2.
- Round-robin fairness: all 4 requesters are held valid continuously with `rsp_ready_i`=1. Required: grant order 0,1,2,3,0; no double grant; `req_ready_o` always one-hot or zero.
- Response backpressure: hold `rsp_ready_i`=0 for 10 cycles while in RESP. Required: `rsp_valid_o`/`rsp_y_o`/`rsp_id_o` stable, no new `req_ready_o` and no `mul_load_o`. Releasing `rsp_ready_i` gives IDLE on the next cycle.
- Stale done: `mul_done_i` stuck at 1 entering RUN. Required: the first RUN cycle is ignored and the product is captured on the second RUN cycle. Full-scale case: a=b=16'hFFFF gives `rsp_y_o`=32'hFFFE0001.
- Reset mid-RUN: drop `rst_i` during RUN. Required: next cycle IDLE with all outputs at reset values. A subsequent request from requester 1 alone is granted to 1 (`ptr` was reset).
- Zero bypass, with the macro defined: a=0, b=500 from requester 3. Required: no `mul_load_o`; `rsp_valid_o` in T+1 with `rsp_y_o`=0 and `rsp_id_o`=3. Without the macro, the full LOAD/RUN path is taken and still yields 0.

Source files
------------

// File: rtl/peasant_mult_arbiter_if.sv
// Bundle of request, multiplier-side and response signals for peasant_mult_arbiter.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface peasant_mult_arbiter_if #(
    parameter int N    = 16,
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
);
    logic [NREQ-1:0]   req_valid_i;
    logic [NREQ*N-1:0] req_a_i;
    logic [NREQ*N-1:0] req_b_i;
    logic [NREQ-1:0]   req_ready_o;
    logic              mul_load_o;
    logic [N-1:0]      mul_a_o;
    logic [N-1:0]      mul_b_o;
    logic              mul_done_i;
    logic [2*N-1:0]    mul_y_i;
    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic [IDW-1:0]    rsp_id_o;
    logic [2*N-1:0]    rsp_y_o;
    logic              busy_o;

    modport slave (
        input  req_valid_i, req_a_i, req_b_i, mul_done_i, mul_y_i, rsp_ready_i,
        output req_ready_o, mul_load_o, mul_a_o, mul_b_o, rsp_valid_o, rsp_id_o,
               rsp_y_o, busy_o
    );

    modport master (
        output req_valid_i, req_a_i, req_b_i, mul_done_i, mul_y_i, rsp_ready_i,
        input  req_ready_o, mul_load_o, mul_a_o, mul_b_o, rsp_valid_o, rsp_id_o,
               rsp_y_o, busy_o
    );
endinterface

// File: rtl/peasant_mult_arbiter.sv
// Round-robin sharing of one shift-add multiplier among NREQ requesters.
// Optional macro PEASANT_ARB_ZERO_BYPASS_EN: zero operands skip the multiplier.
module peasant_mult_arbiter #(
    parameter int N    = 16,
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    peasant_mult_arbiter_if.slave  arb
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [N-1:0]    a_q, a_d;
    logic [N-1:0]    b_q, b_d;
    logic [2*N-1:0]  y_q, y_d;
    logic            run_arm_q, run_arm_d;
    logic            load_q, load_d;
    logic            busy_q, busy_d;
    logic            rsp_valid_q, rsp_valid_d;

    logic            grant_any;
    logic [IDW-1:0]  grant_idx;
    logic [N-1:0]    sel_a, sel_b;
    logic [NREQ-1:0] grant;
    int              ptr_i;

    // Search ptr+1..NREQ-1 first, then wrap to 0..ptr.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        sel_a     = '0;
        sel_b     = '0;
        ptr_i     = int'(ptr_q);
        for (int j = 0; j < NREQ; j++) begin
            if (!grant_any && (j > ptr_i) && arb.req_valid_i[j]) begin
                grant_any = 1'b1;
                grant_idx = IDW'(j);
                sel_a     = arb.req_a_i[j*N +: N];
                sel_b     = arb.req_b_i[j*N +: N];
            end
        end
        for (int j = 0; j < NREQ; j++) begin
            if (!grant_any && (j <= ptr_i) && arb.req_valid_i[j]) begin
                grant_any = 1'b1;
                grant_idx = IDW'(j);
                sel_a     = arb.req_a_i[j*N +: N];
                sel_b     = arb.req_b_i[j*N +: N];
            end
        end
    end

    // The grant is combinational so the handshake completes in the IDLE cycle itself.
    assign grant = (rst_i && (state_q == IDLE) && grant_any)
                   ? (NREQ'(1) << grant_idx) : '0;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        id_d      = id_q;
        a_d       = a_q;
        b_d       = b_q;
        y_d       = y_q;
        run_arm_d = run_arm_q;
        unique case (state_q)
            IDLE: begin
                if (grant_any) begin
                    ptr_d = grant_idx;
                    id_d  = grant_idx;
                    a_d   = sel_a;
                    b_d   = sel_b;
`ifdef PEASANT_ARB_ZERO_BYPASS_EN
                    if ((sel_a == '0) || (sel_b == '0)) begin
                        y_d     = '0;
                        state_d = RESP;
                    end else begin
                        state_d = LOAD;
                    end
`else
                    state_d = LOAD;
`endif
                end
            end
            LOAD: begin
                run_arm_d = 1'b0;
                state_d   = RUN;
            end
            RUN: begin
                // done may still be high from the previous job during the first RUN cycle.
                if (run_arm_q && arb.mul_done_i) begin
                    y_d     = arb.mul_y_i;
                    state_d = RESP;
                end else begin
                    run_arm_d = 1'b1;
                end
            end
            RESP: begin
                if (arb.rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        load_d      = (state_d == LOAD);
        busy_d      = (state_d != IDLE);
        rsp_valid_d = (state_d == RESP);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            ptr_q       <= IDW'(NREQ - 1);
            id_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            y_q         <= '0;
            run_arm_q   <= 1'b0;
            load_q      <= 1'b0;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            a_q         <= a_d;
            b_q         <= b_d;
            y_q         <= y_d;
            run_arm_q   <= run_arm_d;
            load_q      <= load_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign arb.req_ready_o = grant;
    assign arb.mul_load_o  = load_q;
    assign arb.mul_a_o     = a_q;
    assign arb.mul_b_o     = b_q;
    assign arb.rsp_valid_o = rsp_valid_q;
    assign arb.rsp_id_o    = id_q;
    assign arb.rsp_y_o     = y_q;
    assign arb.busy_o      = busy_q;
endmodule
